// File: rtl/csr_pkg.sv
// csr_pkg: CSR addresses, operation encoding and bit positions shared by the CSR/IRQ unit.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;

    typedef enum logic [1:0] {
        CSR_NONE  = 2'b00,
        CSR_WRITE = 2'b01,
        CSR_SET   = 2'b10,
        CSR_CLEAR = 2'b11
    } csr_op_e;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam logic [31:0] MCAUSE_INTR = 32'h8000_0000;

endpackage

// File: rtl/irq_sync.sv
// irq_sync: two-flop synchroniser bank for asynchronous level inputs.
module irq_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/csr_irq_unit.sv
// csr_irq_unit: machine-mode CSR file with prioritised interrupt entry and mret.
// mcycle is kept as a single 2*XLEN counter whose halves map to mcycle/mcycleh.
module csr_irq_unit
    import csr_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter int               NUM_IRQ     = 4,
    parameter int               IRQ_BASE    = 16,
    parameter logic [XLEN-1:0]  RESET_MTVEC = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [XLEN-1:0]     pc,
    input  logic                csr_valid,
    input  logic [1:0]          csr_op,
    input  logic [11:0]         csr_addr,
    input  logic [XLEN-1:0]     csr_wdata,
    output logic [XLEN-1:0]     csr_rdata,
    output logic                csr_illegal,
    input  logic                mret,
    input  logic                core_ready,
    input  logic [NUM_IRQ-1:0]  irq_i,
    output logic                redirect,
    output logic [XLEN-1:0]     redirect_pc,
    output logic                trap_taken
);

    localparam logic [XLEN-1:0] MIE_MASK = XLEN'(((64'd1 << NUM_IRQ) - 64'd1) << IRQ_BASE);

    logic [NUM_IRQ-1:0]  irq_s;
    logic [XLEN-1:0]     mip, pend, mstatus, old_val, wval, cause, vec_pc;
    logic [4:0]          irq_idx;
    logic                legal, wen, take;
    csr_op_e             op;

    logic                mie_bit_q, mie_bit_d, mpie_q, mpie_d;
    logic [XLEN-1:0]     mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [XLEN-1:0]     mepc_q, mepc_d, mcause_q, mcause_d;
    logic [2*XLEN-1:0]   mcycle_q, mcycle_d;

    irq_sync #(.W(NUM_IRQ)) u_irq_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (irq_i),
        .q_o     (irq_s)
    );

    assign op      = csr_op_e'(csr_op);
    assign mip     = XLEN'(irq_s) << IRQ_BASE;
    assign pend    = mip & mie_q;
    assign take    = mie_bit_q & (|pend) & core_ready & ~mret;
    assign mstatus = (XLEN'(mie_bit_q) << MSTATUS_MIE) | (XLEN'(mpie_q) << MSTATUS_MPIE);

    // Ascending scan so the highest pending line overwrites lower ones.
    always_comb begin
        irq_idx = '0;
        for (int i = 0; i < NUM_IRQ; i++)
            if (pend[IRQ_BASE+i]) irq_idx = 5'(i);
    end

    assign cause  = XLEN'(IRQ_BASE) + XLEN'(irq_idx);
    assign vec_pc = {mtvec_q[XLEN-1:2], 2'b00} + (mtvec_q[0] ? (cause << 2) : '0);

    assign trap_taken  = take;
    assign redirect    = take | mret;
    assign redirect_pc = take ? vec_pc : (mret ? mepc_q : '0);

    always_comb begin
        legal   = 1'b1;
        old_val = '0;
        case (csr_addr)
            CSR_MSTATUS:              old_val = mstatus;
            CSR_MIE:                  old_val = mie_q;
            CSR_MTVEC:                old_val = mtvec_q;
            CSR_MSCRATCH:             old_val = mscratch_q;
            CSR_MEPC:                 old_val = mepc_q;
            CSR_MCAUSE:               old_val = mcause_q;
            CSR_MIP:                  old_val = mip;
            CSR_MCYCLE, CSR_CYCLE:    old_val = mcycle_q[XLEN-1:0];
            CSR_MCYCLEH, CSR_CYCLEH:  old_val = mcycle_q[2*XLEN-1:XLEN];
            default:                  legal   = 1'b0;
        endcase
    end

    assign csr_illegal = csr_valid & ~legal;
    assign csr_rdata   = (csr_valid & legal) ? old_val : '0;
    assign wval        = (op == CSR_WRITE) ? csr_wdata :
                         (op == CSR_SET)   ? (old_val | csr_wdata) : (old_val & ~csr_wdata);
    // Set/clear with a zero operand is a pure read; a trap in the same cycle drops the write.
    assign wen         = csr_valid & legal & (op != CSR_NONE) &
                         ~((op != CSR_WRITE) && (csr_wdata == '0)) & ~take;

    always_comb begin
        mie_bit_d  = mie_bit_q;
        mpie_d     = mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mcycle_d   = mcycle_q + 1'b1;
        if (take) begin
            mepc_d    = pc;
            mcause_d  = XLEN'(MCAUSE_INTR) | cause;
            mpie_d    = mie_bit_q;
            mie_bit_d = 1'b0;
        end else if (mret) begin
            mie_bit_d = mpie_q;
            mpie_d    = 1'b1;
        end else if (wen) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mie_bit_d = wval[MSTATUS_MIE];
                    mpie_d    = wval[MSTATUS_MPIE];
                end
                CSR_MIE:      mie_d      = wval & MIE_MASK;
                CSR_MTVEC:    mtvec_d    = wval & ~XLEN'(2);
                CSR_MSCRATCH: mscratch_d = wval;
                CSR_MEPC:     mepc_d     = wval & ~XLEN'(3);
                CSR_MCAUSE:   mcause_d   = wval;
                CSR_MCYCLE:   mcycle_d   = {mcycle_q[2*XLEN-1:XLEN], wval};
                CSR_MCYCLEH:  mcycle_d   = {wval, mcycle_q[XLEN-1:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mie_bit_q  <= 1'b0;
            mpie_q     <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= RESET_MTVEC;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
        end else begin
            mie_bit_q  <= mie_bit_d;
            mpie_q     <= mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
        end
    end

endmodule

// File: tb/tb_csr_irq_unit.sv
// tb_csr_irq_unit: directed test-plan sequences plus random traffic, checked against
// a cycle-level behavioural model of the CSR file and interrupt rules.
module tb_csr_irq_unit;

    localparam int          XLEN        = 32;
    localparam int          NUM_IRQ     = 4;
    localparam int          IRQ_BASE    = 16;
    localparam logic [31:0] RESET_MTVEC = 32'h0;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [31:0]        pc = '0;
    logic               csr_valid = 1'b0;
    logic [1:0]         csr_op = '0;
    logic [11:0]        csr_addr = '0;
    logic [31:0]        csr_wdata = '0;
    logic [31:0]        csr_rdata;
    logic               csr_illegal;
    logic               mret = 1'b0;
    logic               core_ready = 1'b0;
    logic [3:0]         irq_i = '0;
    logic               redirect;
    logic [31:0]        redirect_pc;
    logic               trap_taken;

    csr_irq_unit #(
        .XLEN(XLEN), .NUM_IRQ(NUM_IRQ), .IRQ_BASE(IRQ_BASE), .RESET_MTVEC(RESET_MTVEC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pc(pc), .csr_valid(csr_valid), .csr_op(csr_op),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .csr_illegal(csr_illegal), .mret(mret), .core_ready(core_ready), .irq_i(irq_i),
        .redirect(redirect), .redirect_pc(redirect_pc), .trap_taken(trap_taken)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    bit          m_mie, m_mpie;
    logic [31:0] m_ie, m_tvec, m_scratch, m_epc, m_cause;
    logic [63:0] m_cyc;
    logic [3:0]  irq_hist[$];
    logic [3:0]  irq_v = '0;
    logic [31:0] pc_v = 32'h1000_0040;
    logic        cr_v = 1'b1;

    task automatic model_reset();
        m_mie = 0; m_mpie = 0;
        m_ie = 0; m_tvec = RESET_MTVEC; m_scratch = 0; m_epc = 0; m_cause = 0; m_cyc = 0;
        irq_hist = '{4'h0, 4'h0};
    endtask

    function automatic logic [31:0] model_mip();
        return 32'(irq_hist[0]) * (32'd1 << IRQ_BASE);
    endfunction

    function automatic logic [31:0] mread(input logic [11:0] a, output bit ok);
        ok = 1;
        case (a)
            12'h300: return (m_mpie ? 32'h80 : 32'h0) + (m_mie ? 32'h8 : 32'h0);
            12'h304: return m_ie;
            12'h305: return m_tvec;
            12'h340: return m_scratch;
            12'h341: return m_epc;
            12'h342: return m_cause;
            12'h344: return model_mip();
            12'hB00, 12'hC00: return m_cyc[31:0];
            12'hB80, 12'hC80: return m_cyc[63:32];
            default: begin ok = 0; return 0; end
        endcase
    endfunction

    // One clock cycle: drive, check combinational outputs against the model, advance the model.
    task automatic cyc(input logic v, input logic [1:0] op, input logic [11:0] a,
                       input logic [31:0] wd, input logic mr);
        bit ok, take, we;
        logic [31:0] old, pendv, nv, rpc;
        int idx;
        csr_valid = v; csr_op = op; csr_addr = a; csr_wdata = wd; mret = mr;
        core_ready = cr_v; irq_i = irq_v; pc = pc_v;
        @(negedge clk);
        old   = mread(a, ok);
        pendv = model_mip() & m_ie;
        take  = m_mie && pendv != 0 && cr_v && !mr;
        idx   = -1;
        for (int i = NUM_IRQ - 1; i >= 0 && idx < 0; i--)
            if (pendv[IRQ_BASE+i]) idx = i;
        rpc = (m_tvec % 4 == 1) ? (m_tvec - 1) + 4 * (IRQ_BASE + idx) : m_tvec;
        check("rdata", 64'(csr_rdata), (v && ok) ? 64'(old) : 64'h0);
        check("illegal", 64'(csr_illegal), 64'(v && !ok));
        check("trap_taken", 64'(trap_taken), 64'(take));
        check("redirect", 64'(redirect), 64'(take || mr));
        if (take) check("trap_pc", 64'(redirect_pc), 64'(rpc));
        else if (mr) check("mret_pc", 64'(redirect_pc), 64'(m_epc));
        nv = (op == 2'b01) ? wd : (op == 2'b10) ? (old | wd) : (old & ~wd);
        we = v && ok && op != 0 && !(op != 2'b01 && wd == 0) && !take;
        begin
            logic [63:0] cyc_old;
            cyc_old = m_cyc;
            m_cyc = m_cyc + 1;
            if (take) begin
                m_epc = pc_v; m_cause = 32'h8000_0000 + IRQ_BASE + idx;
                m_mpie = m_mie; m_mie = 0;
            end else if (mr) begin
                m_mie = m_mpie; m_mpie = 1;
            end else if (we) begin
                case (a)
                    12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                    12'h304: m_ie = nv & (32'hF << IRQ_BASE);
                    12'h305: m_tvec = nv & ~32'h2;
                    12'h340: m_scratch = nv;
                    12'h341: m_epc = nv & ~32'h3;
                    12'h342: m_cause = nv;
                    12'hB00: m_cyc = {cyc_old[63:32], nv};
                    12'hB80: m_cyc = {nv, cyc_old[31:0]};
                    default: ;
                endcase
            end
        end
        irq_hist.push_back(irq_v);
        void'(irq_hist.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] a);
        cyc(1, 2'b00, a, 32'h0, 0);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        cyc(1, 2'b01, a, d, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 2'b00, 12'h0, 32'h0, 0);
    endtask

    logic [11:0] addrs[14] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                               12'hB00, 12'hB80, 12'hC00, 12'hC80, 12'h7C0, 12'h301, 12'hF14};

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check("rst_rdata", 64'(csr_rdata), 64'h0);
        check("rst_redirect", 64'(redirect), 64'h0);
        check("rst_trap", 64'(trap_taken), 64'h0);
        check("rst_illegal", 64'(csr_illegal), 64'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        rd(12'h305);
        rd(12'hB00);
        idle(4);
        rd(12'hB00);

        wr(12'h340, 32'hF0F0);
        cyc(1, 2'b10, 12'h340, 32'h000F, 0);
        cyc(1, 2'b11, 12'h340, 32'h00F0, 0);
        rd(12'h340);
        wr(12'h7C0, 32'hDEAD);
        rd(12'h340);

        wr(12'h305, 32'h100);
        wr(12'h304, 32'h1 << 17);
        wr(12'h300, 32'h8);
        irq_v = 4'b0010;
        idle(3);
        rd(12'h341);
        rd(12'h342);
        rd(12'h300);

        pc_v = 32'h1000_0080;
        cyc(0, 2'b00, 12'h0, 32'h0, 1);
        idle(1);
        rd(12'h300);

        irq_v = 4'b1001;
        wr(12'h305, 32'h201);
        wr(12'h304, 32'h0009_0000);
        idle(2);
        wr(12'h300, 32'h8);
        wr(12'h340, 32'h1234);
        rd(12'h340);
        rd(12'h342);

        wr(12'hB00, 32'hFFFF_FFFF);
        wr(12'hB80, 32'h0);
        rd(12'hB00);
        rd(12'hB80);

        cyc(0, 2'b00, 12'h0, 32'h0, 1);
        csr_valid = 0; mret = 0; core_ready = 1; irq_i = irq_v;
        #2;
        check("pre_reset_trap", 64'(trap_taken), 64'h1);
        reset_n = 1'b0;
        #1;
        check("reset_trap", 64'(trap_taken), 64'h0);
        check("reset_redirect", 64'(redirect), 64'h0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(4);
        rd(12'h300);

        for (int n = 0; n < 400; n++) begin
            logic v, mr;
            logic [31:0] wd;
            if ($urandom_range(0, 4) == 0) irq_v = 4'($urandom);
            cr_v = ($urandom_range(0, 4) != 0);
            pc_v = $urandom & ~32'h3;
            mr   = ($urandom_range(0, 9) == 0);
            v    = !mr && ($urandom_range(0, 1) == 1);
            wd   = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) == 0) wd = wd | 32'h8;
            cyc(v, 2'($urandom), addrs[$urandom_range(0, 13)], wd, mr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
